// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : uart_pkg                                                      |
// | Description: Shared definitions for the UART receive path: receive FSM     |
// |              state encoding, default clock/baud settings, frame width and  |
// |              the clocks-per-bit helper.                                    |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
package uart_pkg;

  // Default operating point
  localparam int DEF_CLK_HZ = 50_000_000;
  localparam int DEF_BAUD   = 115200;

  // One frame = start + 8 data + stop
  localparam int FRAME_BITS = 10;

  // Receive FSM state encoding
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] BREAK = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = IDLE,
    S_START = START,
    S_DATA  = DATA,
    S_STOP  = STOP,
    S_DONE  = DONE,
    S_BREAK = BREAK
  } rx_state_e;

  // Integer divide; callers must keep the result >= 4 so the half-bit
  // sample point is meaningful.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_shreg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : uart_rx_shreg                                                 |
// | Description: 10-bit receive shift register. Each shift_en strobe moves the |
// |              register one place toward bit 0 and loads din into q[9].      |
// |              After a full frame: q[0]=start, q[8:1]=data, q[9]=stop.       |
// | Ports      : CLOCK_50 (in,1)  system clock                                 |
// |              reset_n  (in,1)  asynchronous active-low reset                |
// |              shift_en (in,1)  shift strobe                                 |
// |              din      (in,1)  bit to shift in                              |
// |              q        (out,10) register contents                           |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module uart_rx_shreg
  import uart_pkg::*;
(
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic                  shift_en,
  input  logic                  din,
  output logic [FRAME_BITS-1:0] q
);

  logic [FRAME_BITS-1:0] q_q;
  logic [FRAME_BITS-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (shift_en) begin
      q_d = {din, q_q[FRAME_BITS-1:1]};
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_shift_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : uart_rx_shift_ctrl                                            |
// | Description: UART receive sequencer. Synchronises the serial line, detects |
// |              the start bit, times mid-bit sampling, strobes the frame      |
// |              shift register once per bit, validates the stop bit and hands |
// |              the byte to the host with a level-valid / ack handshake and   |
// |              overrun reporting.                                            |
// | Ports      : CLOCK_50   (in,1)  system clock, rising edge                  |
// |              reset_n    (in,1)  asynchronous active-low reset              |
// |              rx         (in,1)  raw serial line, idle high, asynchronous   |
// |              rx_ack     (in,1)  host consumed rx_data (1-cycle pulse)      |
// |              rx_data    (out,8) last good received byte                    |
// |              data_avail (out,1) rx_data holds an unacknowledged byte       |
// |              frame_err  (out,1) pulse: stop bit sampled low                |
// |              overrun    (out,1) pulse: good byte replaced an unacked byte  |
// |              busy       (out,1) receiver not idle                          |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module uart_rx_shift_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_HZ = DEF_CLK_HZ,
  parameter int BAUD   = DEF_BAUD
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       data_avail,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

  // --------------------------------------------------------------------------
  // Two-flop synchroniser; resets to the idle (high) line level so a reset
  // release never looks like a start bit.
  // --------------------------------------------------------------------------
  logic sync1_q;
  logic sync2_q;
  logic rx_s;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  // --------------------------------------------------------------------------
  // Frame shift register
  // --------------------------------------------------------------------------
  logic                  shift_en;
  logic [FRAME_BITS-1:0] shreg_q;

  uart_rx_shreg u_shreg (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .shift_en (shift_en),
    .din      (rx_s),
    .q        (shreg_q)
  );

  // Start and stop positions are checked live on rx_s; only the data bits
  // are read back from the register.
  logic unused_frame_bits;
  assign unused_frame_bits = shreg_q[FRAME_BITS-1] ^ shreg_q[0];

  // --------------------------------------------------------------------------
  // FSM, counters and output registers
  // --------------------------------------------------------------------------
  rx_state_e        state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [3:0]       bitn_q,       bitn_d;
  logic [7:0]       rx_data_q,    rx_data_d;
  logic             data_avail_q, data_avail_d;
  logic             frame_err_q,  frame_err_d;
  logic             overrun_q,    overrun_d;
  logic             busy_q,       busy_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bitn_d       = bitn_q;
    rx_data_d    = rx_data_q;
    data_avail_d = data_avail_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    shift_en     = 1'b0;

    // Host handshake; the DONE branch below overrides this so an ack that
    // coincides with a new byte leaves data_avail set.
    if (rx_ack && data_avail_q) begin
      data_avail_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        if (cnt_q == CNT_MID) begin
          if (rx_s) begin
            // Glitch shorter than half a bit: false start
            state_d = S_IDLE;
          end else begin
            state_d  = S_DATA;
            cnt_d    = '0;
            bitn_d   = '0;
            shift_en = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          shift_en = 1'b1;
          cnt_d    = '0;
          bitn_d   = bitn_q + 4'd1;
          if (bitn_q == 4'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          shift_en = 1'b1;
          cnt_d    = '0;
          if (rx_s) begin
            state_d = S_DONE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        rx_data_d    = shreg_q[8:1];
        data_avail_d = 1'b1;
        overrun_d    = data_avail_q & ~rx_ack;
        state_d      = S_IDLE;
      end

      S_BREAK: begin
        // Hold off until the line returns high so a stuck-low line cannot
        // retrigger a stream of bogus frames.
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered from the next state so busy lines up with state_q
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bitn_q       <= '0;
      rx_data_q    <= '0;
      data_avail_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bitn_q       <= bitn_d;
      rx_data_q    <= rx_data_d;
      data_avail_q <= data_avail_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign data_avail = data_avail_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_shift_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_uart_rx_shift_ctrl                                         |
// | Description: Self-checking bench for uart_rx_shift_ctrl at CLK_HZ=16,      |
// |              BAUD=1 (16 clocks per bit). A frame-level model tracks the    |
// |              expected byte, valid flag and pulse counts.                   |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_uart_rx_shift_ctrl;

  localparam int CPB       = 16;
  localparam int HALF      = CPB / 2;
  localparam int FRAME_CYC = 10 * CPB;
  // Cycles from driving the start edge to data_avail: 2 synchroniser
  // stages plus HALF + 9*CPB + 2 from the synchronised edge.
  localparam int LAT_NOM   = 2 + HALF + 9 * CPB + 2;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n;
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       data_avail;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_shift_ctrl #(
    .CLK_HZ (16),
    .BAUD   (1)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset_n    (reset_n),
    .rx         (rx),
    .rx_ack     (rx_ack),
    .rx_data    (rx_data),
    .data_avail (data_avail),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  // Observed pulse cycles
  int fe_seen = 0;
  int ov_seen = 0;

  always @(negedge CLOCK_50) begin
    if (reset_n) begin
      if (frame_err) fe_seen++;
      if (overrun)   ov_seen++;
    end
  end

  // Reference model state
  logic [7:0] m_data;
  logic       m_avail;
  int         m_fe;
  int         m_ov;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_rx_data"},    32'(rx_data),    32'(m_data));
    check({tag, "_data_avail"}, 32'(data_avail), 32'(m_avail));
    check({tag, "_frame_errs"}, 32'(fe_seen),    32'(m_fe));
    check({tag, "_overruns"},   32'(ov_seen),    32'(m_ov));
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop_ok, input logic ack_on_done);
    if (stop_ok) begin
      if (m_avail && !ack_on_done) m_ov++;
      m_data  = b;
      m_avail = 1'b1;
    end else begin
      m_fe++;
    end
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
    if (m_avail) m_avail = 1'b0;
  endtask

  // Drive n cycles of a frame (start, data LSB-first, stop). ack_k selects
  // the frame cycle on which rx_ack is driven (-1 for none). lat returns the
  // cycle count at which data_avail was first seen rising, or -1.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int n,
                            input int ack_k, output int lat);
    logic [9:0] bits;
    logic       prev;
    bits = {stop_bit, b, 1'b0};
    lat  = -1;
    prev = data_avail;
    for (int k = 0; k < n; k++) begin
      rx     = bits[k / CPB];
      rx_ack = (k == ack_k);
      tick();
      if (lat < 0 && !prev && data_avail === 1'b1) lat = k + 1;
      prev = data_avail;
    end
    rx_ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         lat;
    int         lat1;
    int         dummy;
    logic [7:0] rb;
    logic       rs;

    reset_n = 1'b0;
    rx      = 1'b1;
    rx_ack  = 1'b0;
    m_data  = 8'h00;
    m_avail = 1'b0;
    m_fe    = 0;
    m_ov    = 0;

    // Reset state
    gap(3);
    check_all("reset");
    check("reset_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    gap(3);

    // 1: good frame 0xA5, latency
    send_frame(8'hA5, 1'b1, FRAME_CYC, -1, lat1);
    rx = 1'b1;
    model_frame(8'hA5, 1'b1, 1'b0);
    gap(4);
    check_all("t1");
    check("t1_latency_window", 32'(lat1 >= LAT_NOM - 1 && lat1 <= LAT_NOM + 1), 32'd1);
    check("t1_busy_idle", 32'(busy), 32'd0);
    do_ack();
    check("t1_ack_clears", 32'(data_avail), 32'(m_avail));

    // 2: false start of 4 cycles
    rx = 1'b0;
    gap(4);
    check("t2_busy_during", 32'(busy), 32'd1);
    rx = 1'b1;
    gap(20);
    check("t2_busy_after", 32'(busy), 32'd0);
    check_all("t2");

    // 3: bad stop, line held low, then recovery with 0x55
    send_frame(8'h3C, 1'b0, FRAME_CYC, -1, dummy);
    model_frame(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    gap(40);
    check("t3_busy_break", 32'(busy), 32'd1);
    check_all("t3_break");
    rx = 1'b1;
    gap(8);
    check("t3_busy_released", 32'(busy), 32'd0);
    send_frame(8'h55, 1'b1, FRAME_CYC, -1, dummy);
    rx = 1'b1;
    model_frame(8'h55, 1'b1, 1'b0);
    gap(4);
    check_all("t3_55");
    do_ack();

    // 4: two frames with no ack -> overrun
    send_frame(8'h11, 1'b1, FRAME_CYC, -1, dummy);
    rx = 1'b1;
    model_frame(8'h11, 1'b1, 1'b0);
    gap(4);
    check_all("t4_first");
    send_frame(8'h22, 1'b1, FRAME_CYC, -1, dummy);
    rx = 1'b1;
    model_frame(8'h22, 1'b1, 1'b0);
    gap(4);
    check_all("t4_second");

    // 5: ack on the DONE cycle (one cycle before data_avail would rise)
    lat = (lat1 >= LAT_NOM - 1 && lat1 <= LAT_NOM + 1) ? lat1 : LAT_NOM;
    send_frame(8'h99, 1'b1, FRAME_CYC, lat - 1, dummy);
    rx = 1'b1;
    model_frame(8'h99, 1'b1, 1'b1);
    gap(4);
    check_all("t5_ack_on_done");
    do_ack();
    check_all("t5_later_ack");
    do_ack();
    check_all("t5_ack_ignored");

    // 6: reset in the middle of the fifth data bit
    send_frame(8'h5A, 1'b1, FRAME_CYC, -1, dummy);
    rx = 1'b1;
    model_frame(8'h5A, 1'b1, 1'b0);
    gap(4);
    check_all("t6_pre");
    send_frame(8'hC3, 1'b1, 5 * CPB + HALF, -1, dummy);
    reset_n = 1'b0;
    #1;
    m_data  = 8'h00;
    m_avail = 1'b0;
    check("t6_rst_rx_data",    32'(rx_data),    32'd0);
    check("t6_rst_data_avail", 32'(data_avail), 32'd0);
    check("t6_rst_busy",       32'(busy),       32'd0);
    check("t6_rst_frame_err",  32'(frame_err),  32'd0);
    check("t6_rst_overrun",    32'(overrun),    32'd0);
    rx = 1'b1;
    gap(3);
    reset_n = 1'b1;
    gap(4);
    check("t6_idle_after_rst", 32'(busy), 32'd0);
    send_frame(8'hF0, 1'b1, FRAME_CYC, -1, dummy);
    rx = 1'b1;
    model_frame(8'hF0, 1'b1, 1'b0);
    gap(4);
    check_all("t6_f0");

    // Randomised frames with random stop bits and random acks
    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rb, rs, FRAME_CYC, -1, dummy);
      rx = 1'b1;
      model_frame(rb, rs, 1'b0);
      gap(8);
      check_all("rand_frame");
      check("rand_busy", 32'(busy), 32'd0);
      if ($urandom_range(0, 1) == 1) begin
        do_ack();
        check("rand_ack", 32'(data_avail), 32'(m_avail));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
